radar_target_emulator: RTL and testbench

RADAR_TARGET_EMULATOR -- requirements
Module: radar_target_emulator

---
 rtl/radar_target_emulator.sv | 106 ++++++++++
 tb/tb_radar_target_emulator.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/radar_target_emulator.sv
// radar_target_emulator: emulates a radar target by returning a one-cycle echo pulse after a range-dependent flight time
//
// Ports:
//   clk                        system clock, rising edge
//   rst                        asynchronous active-high reset
//   trigger_radar_transmitter  transmit request; only its rising edge starts a flight
//   target_distance[13:0]      emulated target range in metres
//   target_present             1 = target reflects, 0 = empty sky
//   echo                       registered one-cycle echo pulse
//   emulator_state[1:0]        IDLE=00, FLIGHT=01, ECHO=10, COOLDOWN=11
//   echo_count[7:0]            echoes emitted since reset, wrapping
//
// Optional feature: define RADAR_EMU_DROP_EN to suppress the echo of every 4th accepted trigger.
module radar_target_emulator #(
    parameter int RANGE_PER_CYCLE = 1500,
    parameter int MAX_RANGE_M     = 15000,
    parameter int HOLDOFF_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger_radar_transmitter,
    input  logic [13:0] target_distance,
    input  logic        target_present,
    output logic        echo,
    output logic [1:0]  emulator_state,
    output logic [7:0]  echo_count
);
    localparam int CW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE = 2'b00, FLIGHT = 2'b01, ECHO = 2'b10, COOLDOWN = 2'b11} state_t;

    state_t        state, state_n;
    logic          trig_q, trig_armed, trig_edge;
    logic [14:0]   acc, acc_next;
    logic [15:0]   acc_sum;
    logic [13:0]   dist_l;
    logic          pres_l, hit, timeout, cd_done, drop;
    logic [CW-1:0] cd_cnt;

    // trig_armed blocks a trigger that is already high when reset releases
    assign trig_edge      = trigger_radar_transmitter & ~trig_q & trig_armed;
    assign emulator_state = state;

`ifdef RADAR_EMU_DROP_EN
    logic [1:0] drop_cnt;
    assign drop = drop_cnt == 2'd3;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if (state == IDLE && trig_edge)
            drop_cnt <= drop_cnt + 2'd1;
    end
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        acc_sum  = {1'b0, acc} + 16'(RANGE_PER_CYCLE);
        acc_next = acc_sum[15] ? 15'h7fff : acc_sum[14:0];
        hit      = pres_l && (acc_next >= {1'b0, dist_l});
        timeout  = int'(acc_next) >= MAX_RANGE_M;
        cd_done  = int'(cd_cnt) + 1 >= HOLDOFF_CYCLES;
        state_n  = state == IDLE   ? (trig_edge ? FLIGHT : IDLE) :
                   state == FLIGHT ? (hit ? ECHO : timeout ? IDLE : FLIGHT) :
                   state == ECHO   ? COOLDOWN :
                                     (cd_done ? IDLE : COOLDOWN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q     <= 1'b0;
            trig_armed <= 1'b0;
            echo       <= 1'b0;
            echo_count <= '0;
            acc        <= '0;
            dist_l     <= '0;
            pres_l     <= 1'b0;
            cd_cnt     <= '0;
        end else begin
            trig_q <= trigger_radar_transmitter;
            if (!trigger_radar_transmitter)
                trig_armed <= 1'b1;
            echo <= state_n == ECHO;
            if (state == IDLE && trig_edge) begin
                dist_l <= target_distance;
                pres_l <= target_present & ~drop;
                acc    <= '0;
            end
            if (state == FLIGHT)
                acc <= acc_next;
            if (state == ECHO) begin
                echo_count <= echo_count + 8'd1;
                cd_cnt     <= '0;
            end
            if (state == COOLDOWN)
                cd_cnt <= cd_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_radar_target_emulator.sv
// tb_radar_target_emulator: directed self-checking bench for radar_target_emulator
module tb_radar_target_emulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger_radar_transmitter = 1'b0;
    logic [13:0] target_distance = '0;
    logic        target_present = 1'b0;
    logic        echo;
    logic [1:0]  emulator_state;
    logic [7:0]  echo_count;

    int checks = 0;
    int failures = 0;
    int lat, n_echo;
    int st [0:14];

    radar_target_emulator dut (
        .clk(clk),
        .rst(rst),
        .trigger_radar_transmitter(trigger_radar_transmitter),
        .target_distance(target_distance),
        .target_present(target_present),
        .echo(echo),
        .emulator_state(emulator_state),
        .echo_count(echo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // trigger sampled high at edge N; returns at the negedge after edge N
    task automatic fire(input int d, input logic p, input logic hold);
        @(negedge clk);
        target_distance = 14'(d);
        target_present = p;
        trigger_radar_transmitter = 1'b1;
        @(negedge clk);
        if (!hold) trigger_radar_transmitter = 1'b0;
    endtask

    // st[i]/echo observed after edge N+i; retrig>0 re-pulses the trigger at edge N+retrig
    task automatic measure(input int retrig);
        lat = -1;
        n_echo = 0;
        st[0] = int'(emulator_state);
        for (int i = 1; i < 15; i++) begin
            if (i == retrig) trigger_radar_transmitter = 1'b1;
            else if (retrig > 0 && i == retrig + 1) trigger_radar_transmitter = 1'b0;
            @(negedge clk);
            st[i] = int'(emulator_state);
            if (echo) begin
                n_echo++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int seq_exp [0:5];
        seq_exp = '{1, 1, 2, 3, 3, 0};
        @(negedge clk);
        @(negedge clk);
        check("rst_state", int'(emulator_state), 0);
        check("rst_echo", int'(echo), 0);
        check("rst_count", int'(echo_count), 0);
        rst = 1'b0;

        fire(3000, 1'b1, 1'b0);
        measure(0);
        check("d3000_lat", lat, 2);
        check("d3000_n", n_echo, 1);
        for (int i = 0; i < 6; i++) check($sformatf("d3000_st%0d", i), st[i], seq_exp[i]);
        check("d3000_count", int'(echo_count), 1);

        fire(3001, 1'b1, 1'b0);
        measure(0);
        check("d3001_lat", lat, 3);
        fire(0, 1'b1, 1'b0);
        measure(0);
        check("d0_lat", lat, 1);
        fire(15000, 1'b1, 1'b0);
        measure(0);
        check("d15000_lat", lat, 10);
        check("d15000_count", int'(echo_count), 4);

        fire(15001, 1'b1, 1'b0);
        measure(0);
        check("d15001_n", n_echo, 0);
        check("d15001_st9", st[9], 1);
        check("d15001_st10", st[10], 0);
        check("d15001_count", int'(echo_count), 4);

        fire(1500, 1'b0, 1'b0);
        measure(3);
        check("absent_n", n_echo, 0);
        check("absent_st9", st[9], 1);
        check("absent_st10", st[10], 0);
        check("absent_st14", st[14], 0);
        check("absent_count", int'(echo_count), 4);

        fire(1500, 1'b1, 1'b1);
        measure(0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (echo) n_echo++;
        end
        trigger_radar_transmitter = 1'b0;
        check("held_lat", lat, 1);
        check("held_n", n_echo, 1);
        check("held_count", int'(echo_count), 5);

        fire(9000, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        measure(0);
        check("abort_n", n_echo, 0);
        check("abort_state", st[14], 0);
        check("abort_count", int'(echo_count), 0);
        fire(4500, 1'b1, 1'b0);
        measure(0);
        check("d4500_lat", lat, 3);
        check("d4500_count", int'(echo_count), 1);

        trigger_radar_transmitter = 1'b1;
        target_distance = 14'd1500;
        target_present = 1'b1;
        pulse_reset();
        measure(0);
        check("rst_held_n", n_echo, 0);
        check("rst_held_st2", st[2], 0);
        trigger_radar_transmitter = 1'b0;
        fire(1500, 1'b1, 1'b0);
        measure(0);
        check("rearm_lat", lat, 1);

        pulse_reset();
        for (int t = 1; t <= 8; t++) begin
            fire(1500, 1'b1, 1'b0);
            measure(0);
`ifdef RADAR_EMU_DROP_EN
            check($sformatf("drop_t%0d", t), n_echo, (t % 4 == 0) ? 0 : 1);
`else
            check($sformatf("drop_t%0d", t), n_echo, 1);
`endif
        end
`ifdef RADAR_EMU_DROP_EN
        check("drop_count", int'(echo_count), 6);
`else
        check("drop_count", int'(echo_count), 8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
